logic_lock_key_loader: RTL and testbench

- Serial key-provisioning stage sitting directly upstream of the locked c432 netlist.
- Receives a key frame bit-serially through a valid/ready handshake and checks a CRC-8 tag on the frame.
- Only after a successful check does it commit the key to the parallel key bus. That bus drives the netlist's p1..p4 and X_1..X_88 key inputs.
- The committed key stays stable between loads, so the combinational netlist never sees a partial key.

---
 rtl/logic_lock_key_loader.sv | 146 ++++++++++++++
 tb/tb_logic_lock_key_loader.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_lock_key_loader.sv
// Serial key loader for the locked c432 netlist.
// Key bits arrive one per valid/ready transfer and are protected by an optional CRC-8 tag.
// The key bus (p and X inputs of the netlist) changes only when a complete, verified frame commits.
module logic_lock_key_loader #(
    parameter int P_BITS = 4,
    parameter int X_BITS = 88,
    parameter bit CRC_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear,
    input  logic              key_in_bit,
    input  logic              key_in_valid,
    output logic              key_in_ready,
    output logic [P_BITS-1:0] key_p,
    output logic [X_BITS-1:0] key_x,
    output logic              key_valid,
    output logic              busy,
    output logic              load_err
);

    localparam int KEY_BITS = P_BITS + X_BITS;
    localparam int CNT_W    = $clog2(KEY_BITS + 1);

    localparam logic [CNT_W-1:0] LAST_KEY_IDX = CNT_W'(KEY_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_TAG_IDX = CNT_W'(7);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [7:0]       CRC_POLY     = 8'h07;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_TAG   = 2'd2;
    localparam logic [1:0] S_CHECK = 2'd3;

    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [KEY_BITS-1:0] r_stage;
    logic [7:0]          r_crc;
    logic [7:0]          r_tag;
    logic [P_BITS-1:0]   r_keyP;
    logic [X_BITS-1:0]   r_keyX;
    logic                r_keyValid;
    logic                r_loadErr;

    logic                w_xfer;
    logic                w_crcFeedback;
    logic [7:0]          w_crcNext;
    logic                w_tagMatch;

    // Ready is decoded straight from the registered state so it never depends on the inputs.
    assign key_in_ready = (r_state == S_SHIFT) || (r_state == S_TAG);
    assign w_xfer       = key_in_valid && key_in_ready;
    assign w_tagMatch   = (r_tag == r_crc);

    // Next CRC value for the incoming key bit, MSB-first LFSR with polynomial 0x07.
    always_comb begin
        w_crcFeedback = r_crc[7] ^ key_in_bit;
        w_crcNext     = {r_crc[6:0], 1'b0} ^ (w_crcFeedback ? CRC_POLY : 8'h00);
    end

    // Frame sequencing: collect key bits into staging, then the tag, then hand over to the check cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_stage <= '0;
            r_crc   <= '0;
            r_tag   <= '0;
        end else if (clear) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_SHIFT;
                        r_cnt   <= '0;
                        r_crc   <= 8'h00;
                    end
                end
                S_SHIFT: begin
                    if (w_xfer) begin
                        r_stage[r_cnt] <= key_in_bit;
                        r_crc          <= w_crcNext;
                        if (r_cnt == LAST_KEY_IDX) begin
                            r_cnt   <= '0;
                            r_state <= CRC_EN ? S_TAG : S_CHECK;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                end
                S_TAG: begin
                    if (w_xfer) begin
                        r_tag <= {r_tag[6:0], key_in_bit};
                        if (r_cnt == LAST_TAG_IDX) begin
                            r_cnt   <= '0;
                            r_state <= S_CHECK;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                end
                S_CHECK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Commit the staged key on a good check, otherwise raise a one-cycle error; clear wipes the committed key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_keyP     <= '0;
            r_keyX     <= '0;
            r_keyValid <= 1'b0;
            r_loadErr  <= 1'b0;
        end else begin
            r_loadErr <= 1'b0;
            if (clear) begin
                r_keyP     <= '0;
                r_keyX     <= '0;
                r_keyValid <= 1'b0;
            end else if (r_state == S_CHECK) begin
                if (!CRC_EN || w_tagMatch) begin
                    r_keyP     <= r_stage[P_BITS-1:0];
                    r_keyX     <= r_stage[KEY_BITS-1:P_BITS];
                    r_keyValid <= 1'b1;
                end else begin
                    r_loadErr <= 1'b1;
                end
            end
        end
    end

    assign key_p     = r_keyP;
    assign key_x     = r_keyX;
    assign key_valid = r_keyValid;
    assign load_err  = r_loadErr;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_logic_lock_key_loader.sv
// Self-checking bench for logic_lock_key_loader.
// Two instances are exercised: one with the CRC tag enabled and one without.
// Expected keys and CRC tags come from a frame-level model (polynomial long division over the key bits).
module tb_logic_lock_key_loader;

    localparam int P_BITS   = 4;
    localparam int X_BITS   = 88;
    localparam int KEY_BITS = P_BITS + X_BITS;

    typedef logic bitq_t[$];

    logic clk = 1'b0;
    logic rst;

    logic startIn, clearIn, bitIn, validIn;
    bit   selDut;

    logic              start1, clear1, bit1, valid1, ready1, keyValid1, busy1, loadErr1;
    logic [P_BITS-1:0] keyP1;
    logic [X_BITS-1:0] keyX1;
    logic              start0, clear0, bit0, valid0, ready0, keyValid0, busy0, loadErr0;
    logic [P_BITS-1:0] keyP0;
    logic [X_BITS-1:0] keyX0;

    logic              obsReady, obsValid, obsBusy, obsErr;
    logic [P_BITS-1:0] obsP;
    logic [X_BITS-1:0] obsX;

    logic              expValidM [2];
    logic [P_BITS-1:0] expPM     [2];
    logic [X_BITS-1:0] expXM     [2];

    int checks = 0;
    int errors = 0;

    bitq_t               frame;
    logic [KEY_BITS-1:0] key;
    logic [7:0]          tag;
    int                  xfers;
    int                  readyCycles;

    always #5 clk = ~clk;

    // The selected instance gets the shared stimulus; the other sees idle inputs.
    assign start1 = selDut & startIn;
    assign clear1 = selDut & clearIn;
    assign bit1   = selDut & bitIn;
    assign valid1 = selDut & validIn;
    assign start0 = !selDut & startIn;
    assign clear0 = !selDut & clearIn;
    assign bit0   = !selDut & bitIn;
    assign valid0 = !selDut & validIn;

    assign obsReady = selDut ? ready1    : ready0;
    assign obsValid = selDut ? keyValid1 : keyValid0;
    assign obsBusy  = selDut ? busy1     : busy0;
    assign obsErr   = selDut ? loadErr1  : loadErr0;
    assign obsP     = selDut ? keyP1     : keyP0;
    assign obsX     = selDut ? keyX1     : keyX0;

    logic_lock_key_loader #(.P_BITS(P_BITS), .X_BITS(X_BITS), .CRC_EN(1'b1)) dutCrc (
        .clk(clk), .rst(rst), .start(start1), .clear(clear1),
        .key_in_bit(bit1), .key_in_valid(valid1), .key_in_ready(ready1),
        .key_p(keyP1), .key_x(keyX1), .key_valid(keyValid1), .busy(busy1), .load_err(loadErr1)
    );

    logic_lock_key_loader #(.P_BITS(P_BITS), .X_BITS(X_BITS), .CRC_EN(1'b0)) dutRaw (
        .clk(clk), .rst(rst), .start(start0), .clear(clear0),
        .key_in_bit(bit0), .key_in_valid(valid0), .key_in_ready(ready0),
        .key_p(keyP0), .key_x(keyX0), .key_valid(keyValid0), .busy(busy0), .load_err(loadErr0)
    );

    // CRC as the remainder of M(x)*x^8 divided by x^8+x^2+x+1, first-arriving bit as highest degree.
    function automatic logic [7:0] modelCrc(input logic [KEY_BITS-1:0] k);
        int         m [KEY_BITS+8];
        logic [7:0] rem;
        for (int i = 0; i < KEY_BITS + 8; i++) m[i] = (i < KEY_BITS) ? int'(k[i]) : 0;
        for (int i = 0; i < KEY_BITS; i++) begin
            if (m[i] == 1) begin
                m[i]   ^= 1;
                m[i+6] ^= 1;
                m[i+7] ^= 1;
                m[i+8] ^= 1;
            end
        end
        for (int i = 0; i < 8; i++) rem[7-i] = (m[KEY_BITS+i] != 0);
        return rem;
    endfunction

    // Key bits in arrival order, optionally followed by the tag MSB first.
    function automatic bitq_t makeFrame(input logic [KEY_BITS-1:0] k, input bit withTag, input logic [7:0] t);
        bitq_t q;
        for (int i = 0; i < KEY_BITS; i++) q.push_back(k[i]);
        if (withTag) for (int i = 7; i >= 0; i--) q.push_back(t[i]);
        return q;
    endfunction

    function automatic logic [KEY_BITS-1:0] randKey();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[KEY_BITS-1:0];
    endfunction

    task automatic checkOutput(input string name, input logic [95:0] observed, input logic [95:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    task automatic checkKey(input string name);
        int s;
        s = selDut ? 1 : 0;
        checkOutput({name, ".valid"}, obsValid, expValidM[s]);
        checkOutput({name, ".keyP"},  obsP,     expPM[s]);
        checkOutput({name, ".keyX"},  obsX,     expXM[s]);
    endtask

    task automatic startFrame();
        @(negedge clk);
        startIn = 1'b1;
        clearIn = 1'b0;
    endtask

    // Drive a frame with a bounded cycle budget; the committed key must not move and no error may pulse meanwhile.
    task automatic applyStimulus(input string name, input bitq_t f, input bit toggle, input int startPulseIdx,
                                 output int nXfer, output int nReady);
        int idx;
        int cyc;
        bit phase;
        bit isolationBad;
        int s;
        s = selDut ? 1 : 0;
        idx = 0;
        cyc = 0;
        phase = 1'b1;
        isolationBad = 1'b0;
        nReady = 0;
        while (idx < f.size() && cyc < 2000) begin
            @(negedge clk);
            if (obsValid !== expValidM[s] || obsP !== expPM[s] || obsX !== expXM[s] || obsErr !== 1'b0)
                isolationBad = 1'b1;
            startIn = (idx == startPulseIdx);
            clearIn = 1'b0;
            validIn = toggle ? phase : 1'b1;
            phase   = ~phase;
            bitIn   = f[idx];
            if (obsReady) nReady++;
            if (validIn && obsReady) idx++;
            cyc++;
        end
        nXfer = idx;
        checkOutput({name, ".frameDone"}, idx, f.size());
        checkOutput({name, ".isolation"}, isolationBad, 1'b0);
    endtask

    // Check cycle keeps the old key; the following cycle shows the commit or the error pulse, which then drops.
    task automatic postCheck(input string name, input bit expectOk, input logic [KEY_BITS-1:0] k);
        int s;
        s = selDut ? 1 : 0;
        @(negedge clk);
        validIn = 1'b0;
        startIn = 1'b0;
        checkOutput({name, ".checkReady"}, obsReady, 1'b0);
        checkOutput({name, ".checkBusy"},  obsBusy,  1'b1);
        checkKey({name, ".held"});
        @(negedge clk);
        if (expectOk) begin
            expValidM[s] = 1'b1;
            expPM[s]     = k[P_BITS-1:0];
            expXM[s]     = k[KEY_BITS-1:P_BITS];
        end
        checkKey({name, ".commit"});
        checkOutput({name, ".loadErr"}, obsErr,  !expectOk);
        checkOutput({name, ".busy"},    obsBusy, 1'b0);
        @(negedge clk);
        checkOutput({name, ".errDrop"}, obsErr, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        startIn = 1'b0;
        clearIn = 1'b0;
        bitIn = 1'b0;
        validIn = 1'b0;
        selDut = 1'b1;
        for (int i = 0; i < 2; i++) begin
            expValidM[i] = 1'b0;
            expPM[i] = '0;
            expXM[i] = '0;
        end

        // Reset state of both instances.
        #12;
        for (int i = 0; i < 2; i++) begin
            selDut = (i == 1);
            #1;
            checkKey("reset");
            checkOutput("reset.ready", obsReady, 1'b0);
            checkOutput("reset.busy", obsBusy, 1'b0);
            checkOutput("reset.loadErr", obsErr, 1'b0);
        end
        selDut = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] all-zero frame with tag 0x00");
        key = '0;
        checkOutput("zero.crcModel", modelCrc(key), 8'h00);
        startFrame();
        applyStimulus("zero", makeFrame(key, 1'b1, 8'h00), 1'b0, -1, xfers, readyCycles);
        checkOutput("zero.xfers", xfers, 100);
        checkOutput("zero.readyCycles", readyCycles, 100);
        postCheck("zero", 1'b1, key);

        $display("[TB] random frames, good and corrupted tags");
        for (int n = 0; n < 4; n++) begin
            bit bad;
            bad = (n == 1) || ($urandom_range(0, 2) == 0);
            key = randKey();
            tag = modelCrc(key);
            if (bad) tag = tag ^ 8'($urandom_range(1, 255));
            startFrame();
            applyStimulus("rand", makeFrame(key, 1'b1, tag), $urandom_range(0, 1) == 1, -1, xfers, readyCycles);
            postCheck("rand", !bad, key);
        end

        $display("[TB] zero frame with wrong tag 0x5A over a committed key");
        key = randKey();
        startFrame();
        applyStimulus("preload", makeFrame(key, 1'b1, modelCrc(key)), 1'b0, -1, xfers, readyCycles);
        postCheck("preload", 1'b1, key);
        key = '0;
        startFrame();
        applyStimulus("badTag", makeFrame(key, 1'b1, 8'h5A), 1'b0, -1, xfers, readyCycles);
        postCheck("badTag", 1'b0, key);

        $display("[TB] untagged instance, p=1010 and alternating x, toggling valid");
        selDut = 1'b0;
        key[P_BITS-1:0] = 4'b1010;
        for (int i = 0; i < X_BITS; i++) key[P_BITS+i] = (i % 2 == 0);
        startFrame();
        applyStimulus("raw", makeFrame(key, 1'b0, 8'h00), 1'b1, -1, xfers, readyCycles);
        checkOutput("raw.xfers", xfers, KEY_BITS);
        postCheck("raw", 1'b1, key);
        checkOutput("raw.keyP", obsP, 4'hA);
        checkOutput("raw.keyX", obsX, {(X_BITS/2){2'b01}});
        key = randKey();
        startFrame();
        applyStimulus("rawRand", makeFrame(key, 1'b0, 8'h00), 1'b0, -1, xfers, readyCycles);
        postCheck("rawRand", 1'b1, key);
        selDut = 1'b1;

        $display("[TB] reset after 40 bits, then a fresh frame");
        key = randKey();
        frame = makeFrame(key, 1'b1, modelCrc(key));
        startFrame();
        applyStimulus("partial", frame[0:39], 1'b0, -1, xfers, readyCycles);
        @(negedge clk);
        validIn = 1'b0;
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            expValidM[i] = 1'b0;
            expPM[i] = '0;
            expXM[i] = '0;
        end
        checkKey("midReset");
        checkOutput("midReset.busy", obsBusy, 1'b0);
        checkOutput("midReset.ready", obsReady, 1'b0);
        #1 rst = 1'b0;
        key = randKey();
        startFrame();
        applyStimulus("afterReset", makeFrame(key, 1'b1, modelCrc(key)), 1'b0, -1, xfers, readyCycles);
        postCheck("afterReset", 1'b1, key);

        $display("[TB] clear during SHIFT over a committed key");
        frame = makeFrame(randKey(), 1'b1, 8'h00);
        startFrame();
        applyStimulus("preClear", frame[0:29], 1'b0, -1, xfers, readyCycles);
        @(negedge clk);
        clearIn = 1'b1;
        validIn = 1'b1;
        @(negedge clk);
        clearIn = 1'b0;
        validIn = 1'b0;
        expValidM[1] = 1'b0;
        expPM[1] = '0;
        expXM[1] = '0;
        checkKey("clear");
        checkOutput("clear.busy", obsBusy, 1'b0);
        checkOutput("clear.ready", obsReady, 1'b0);
        checkOutput("clear.loadErr", obsErr, 1'b0);

        $display("[TB] start and clear together");
        @(negedge clk);
        startIn = 1'b1;
        clearIn = 1'b1;
        @(negedge clk);
        startIn = 1'b0;
        clearIn = 1'b0;
        checkOutput("startClear.busy", obsBusy, 1'b0);

        $display("[TB] valid held in IDLE, start pulsed during TAG");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            validIn = 1'b1;
            bitIn = 1'($urandom_range(0, 1));
            checkOutput("idleValid.ready", obsReady, 1'b0);
            checkOutput("idleValid.busy", obsBusy, 1'b0);
        end
        key = randKey();
        startFrame();
        applyStimulus("tagStart", makeFrame(key, 1'b1, modelCrc(key)), 1'b0, KEY_BITS + 3, xfers, readyCycles);
        checkOutput("tagStart.readyCycles", readyCycles, 100);
        postCheck("tagStart", 1'b1, key);

        $display("[TB] clear in the CHECK cycle beats the commit");
        key = randKey();
        startFrame();
        applyStimulus("checkClear", makeFrame(key, 1'b1, modelCrc(key)), 1'b0, -1, xfers, readyCycles);
        @(negedge clk);
        validIn = 1'b0;
        clearIn = 1'b1;
        checkOutput("checkClear.inCheck", obsBusy, 1'b1);
        @(negedge clk);
        clearIn = 1'b0;
        expValidM[1] = 1'b0;
        expPM[1] = '0;
        expXM[1] = '0;
        checkKey("checkClear");
        checkOutput("checkClear.loadErr", obsErr, 1'b0);
        checkOutput("checkClear.busy", obsBusy, 1'b0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
